// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 text controller: FSM states, LCD command bytes, bus record.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_DELAY      = 3'd0,
      ST_FUNC_SET   = 3'd1,
      ST_DISP_ONOFF = 3'd2,
      ST_ENTRY_MODE = 3'd3,
      ST_LINE1      = 3'd4,
      ST_LINE2      = 3'd5,
      ST_IDLE       = 3'd6
   } lcd_state_e;

   localparam logic [7:0] CMD_LINE1   = 8'h80;
   localparam logic [7:0] CMD_LINE2   = 8'hC0;
   localparam logic [7:0] CMD_DISP_ON = 8'h0C;
   localparam logic [7:0] CMD_ENTRY   = 8'h06;
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CHAR_SPACE  = 8'h20;

   typedef struct packed {
      logic       rs;
      logic       rw;
      logic [7:0] data;
   } lcd_bus_t;

endpackage

// File: rtl/lcd_text_buf.sv
// Two-line character buffer: synchronous write, combinational read, resets to spaces.
module lcd_text_buf
   import lcd_pkg::*;
#(
   parameter int COLS   = 16,
   parameter int ADDR_W = $clog2(2 * COLS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [7:0]        wr_char_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [7:0]        rd_char_o,
   output logic              wr_ok_o
);

   localparam int DEPTH = 2 * COLS;

   logic [7:0] mem_q [DEPTH];

   // Addresses past the second line are dropped entirely, so they never mark the screen dirty.
   assign wr_ok_o   = wr_en_i && (int'(wr_addr_i) < DEPTH);
   assign rd_char_o = mem_q[rd_addr_i];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= CHAR_SPACE;
         end
      end else if (wr_ok_o) begin
         mem_q[wr_addr_i] <= wr_char_i;
      end
   end

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 character-LCD controller: power-on init, then redraws a writable 2-line text buffer.
module lcd_text_ctrl
   import lcd_pkg::*;
#(
   parameter int         COLS         = 16,
   parameter int         INIT_WAIT    = 70,
   parameter int         CMD_CYC      = 30,
   parameter int         AUTO_REFRESH = 1,
   parameter logic [7:0] FUNC_CODE    = 8'h3C,
   localparam int        ADDR_W       = $clog2(2 * COLS)
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              WR_EN,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [7:0]        WR_CHAR,
   input  logic              REFRESH_REQ,
   output logic              BUSY,
   output logic              LCD_E,
   output logic              LCD_RS,
   output logic              LCD_RW,
   output logic [7:0]        LCD_DATA
);

   localparam int CNT_MAX = (INIT_WAIT > CMD_CYC) ? ((INIT_WAIT > COLS) ? INIT_WAIT : COLS)
                                                  : ((CMD_CYC > COLS) ? CMD_CYC : COLS);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   lcd_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              dirty_q;
   lcd_bus_t          bus_q;
   lcd_bus_t          bus_d;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_char;
   logic              wr_ok;
   logic              cnt_done;
   logic              redraw;
   logic              enter_line1;
   int                rd_idx;

   function automatic logic [CNT_W-1:0] last_cnt(lcd_state_e s);
      case (s)
         ST_DELAY:                                  return CNT_W'(INIT_WAIT);
         ST_FUNC_SET, ST_DISP_ONOFF, ST_ENTRY_MODE: return CNT_W'(CMD_CYC);
         default:                                   return CNT_W'(COLS);
      endcase
   endfunction

   function automatic lcd_state_e next_state(lcd_state_e s);
      case (s)
         ST_DELAY:      return ST_FUNC_SET;
         ST_FUNC_SET:   return ST_DISP_ONOFF;
         ST_DISP_ONOFF: return ST_ENTRY_MODE;
         ST_ENTRY_MODE: return ST_LINE1;
         ST_LINE1:      return ST_LINE2;
         default:       return ST_IDLE;
      endcase
   endfunction

   // Slot 0 of each line carries the DDRAM address command, slots 1..COLS the characters.
   function automatic lcd_bus_t bus_for(lcd_state_e s, logic [CNT_W-1:0] c, logic [7:0] ch);
      lcd_bus_t b;
      b = '{rs: 1'b0, rw: 1'b0, data: 8'h00};
      case (s)
         ST_DELAY:      b = '{rs: 1'b1, rw: 1'b1, data: 8'h00};
         ST_FUNC_SET:   b.data = FUNC_CODE;
         ST_DISP_ONOFF: b.data = CMD_DISP_ON;
         ST_ENTRY_MODE: b.data = CMD_ENTRY;
         ST_LINE1, ST_LINE2: begin
            if (c == '0) begin
               b.data = (s == ST_LINE1) ? CMD_LINE1 : CMD_LINE2;
            end else begin
               b.rs   = 1'b1;
               b.data = ch;
            end
         end
         default: ;
      endcase
      return b;
   endfunction

   always_comb begin
      rd_idx = 0;
      if ((state_q == ST_LINE1 || state_q == ST_LINE2) && cnt_q != '0) begin
         rd_idx = ((state_q == ST_LINE2) ? COLS : 0) + int'(cnt_q) - 1;
      end
      rd_addr = ADDR_W'(rd_idx);
   end

   lcd_text_buf #(
      .COLS   (COLS),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk_i     (CLK),
      .rst_i     (RESETN),
      .wr_en_i   (WR_EN),
      .wr_addr_i (WR_ADDR),
      .wr_char_i (WR_CHAR),
      .rd_addr_i (rd_addr),
      .rd_char_o (rd_char),
      .wr_ok_o   (wr_ok)
   );

   assign cnt_done    = (cnt_q == last_cnt(state_q));
   assign redraw      = (state_q == ST_IDLE) && (REFRESH_REQ || (AUTO_REFRESH != 0 && dirty_q));
   assign enter_line1 = redraw || (state_q == ST_ENTRY_MODE && cnt_done);
   assign bus_d       = bus_for(state_q, cnt_q, rd_char);

   always_ff @(posedge CLK or posedge RESETN) begin
      if (RESETN) begin
         state_q <= ST_DELAY;
         cnt_q   <= '0;
         dirty_q <= 1'b1;
         bus_q   <= '{rs: 1'b0, rw: 1'b1, data: 8'h00};
      end else begin
         bus_q <= bus_d;
         // A write landing on the same edge a pass starts is already in that pass.
         if (enter_line1) begin
            dirty_q <= 1'b0;
         end else if (wr_ok) begin
            dirty_q <= 1'b1;
         end
         if (state_q == ST_IDLE) begin
            cnt_q <= '0;
            if (redraw) begin
               state_q <= ST_LINE1;
            end
         end else if (cnt_done) begin
            state_q <= next_state(state_q);
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign BUSY     = (state_q != ST_IDLE);
   assign LCD_E    = CLK;
   assign LCD_RS   = bus_q.rs;
   assign LCD_RW   = bus_q.rw;
   assign LCD_DATA = bus_q.data;

endmodule
